// File: rtl/instr_feeder.sv
// instr_feeder: fetches 9-bit instruction words from a synchronous ROM and issues
// them to the processor over DIN/Run, supplying mvi immediates and waiting for Done.
module instr_feeder #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 7
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Done,
  input  logic [8:0]        MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [7:0]        IssueCount
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FI,
    LI,
    LM,
    ISSUE,
    EXEC,
    HALTED,
    ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [8:0]        instr_reg;
  logic [8:0]        imm_reg;
  logic [TW-1:0]     timeout_cnt;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;
  logic              instr_is_mvi;

  assign pc_plus1     = pc + ADDR_W'(1);
  assign pc_plus2     = pc + ADDR_W'(2);
  assign instr_is_mvi = (instr_reg[8:6] == OP_MVI);

  // Outputs are registered: each transition also loads the outputs the next state presents.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state       <= IDLE;
      pc          <= '0;
      instr_reg   <= '0;
      imm_reg     <= '0;
      timeout_cnt <= '0;
      IssueCount  <= '0;
      DIN         <= '0;
      MemAddr     <= '0;
      Run         <= 1'b0;
      Busy        <= 1'b0;
      Halted      <= 1'b0;
      Error       <= 1'b0;
    end else begin
      Run <= 1'b0;
      case (state)
        IDLE, HALTED: begin
          if (Start) begin
            state      <= FI;
            pc         <= '0;
            IssueCount <= '0;
            MemAddr    <= '0;
            Busy       <= 1'b1;
            Halted     <= 1'b0;
          end
        end
        FI: begin
          state   <= LI;
          MemAddr <= pc_plus1;
        end
        LI: begin
          instr_reg <= MemData;
          DIN       <= MemData;
          MemAddr   <= pc;
          if (MemData[8:6] == OP_HALT) begin
            state  <= HALTED;
            Busy   <= 1'b0;
            Halted <= 1'b1;
          end else if (MemData[8:6] == OP_MVI) begin
            state <= LM;
          end else begin
            state <= ISSUE;
            Run   <= 1'b1;
          end
        end
        LM: begin
          imm_reg <= MemData;
          state   <= ISSUE;
          Run     <= 1'b1;
        end
        ISSUE: begin
          state       <= EXEC;
          IssueCount  <= IssueCount + 8'd1;
          timeout_cnt <= '0;
          // The processor latches IR at this edge, so DIN can switch to the immediate for T0.
          DIN         <= instr_is_mvi ? imm_reg : instr_reg;
        end
        EXEC: begin
          if (Done) begin
            state   <= FI;
            pc      <= instr_is_mvi ? pc_plus2 : pc_plus1;
            MemAddr <= instr_is_mvi ? pc_plus2 : pc_plus1;
            DIN     <= instr_reg;
          end else if (timeout_cnt == TW'(TIMEOUT)) begin
            state <= ERROR;
            Busy  <= 1'b0;
            Error <= 1'b1;
            DIN   <= instr_reg;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: directed bench driving two feeders (ADDR_W=5 and ADDR_W=2) against
// bench-side synchronous ROMs, with Done pulses placed by hand.
module tb_instr_feeder;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Start;
  logic       Done;

  logic [8:0] memData1;
  logic [4:0] memAddr1;
  logic [8:0] din1;
  logic       run1, busy1, halted1, error1;
  logic [7:0] issueCount1;

  logic [8:0] memData2;
  logic [1:0] memAddr2;
  logic [8:0] din2;
  logic       run2, busy2, halted2, error2;
  logic [7:0] issueCount2;

  logic [8:0] rom1 [0:31];
  logic [8:0] rom2 [0:3];

  int checks = 0;
  int errors = 0;
  int runCount = 0;

  always #5 Clock = ~Clock;

  instr_feeder #(.ADDR_W(5), .TIMEOUT(7)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Done(Done),
    .MemData(memData1), .MemAddr(memAddr1), .DIN(din1), .Run(run1),
    .Busy(busy1), .Halted(halted1), .Error(error1), .IssueCount(issueCount1)
  );

  instr_feeder #(.ADDR_W(2), .TIMEOUT(7)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Done(Done),
    .MemData(memData2), .MemAddr(memAddr2), .DIN(din2), .Run(run2),
    .Busy(busy2), .Halted(halted2), .Error(error2), .IssueCount(issueCount2)
  );

  always @(posedge Clock) begin
    memData1 <= rom1[memAddr1];
    memData2 <= rom2[memAddr2];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance n cycles; outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      if (run1) runCount++;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic d);
    Start = s;
    Done  = d;
    step(1);
    Start = 1'b0;
    Done  = 1'b0;
  endtask

  task automatic doReset();
    Resetn = 1'b0;
    Start  = 1'b0;
    Done   = 1'b0;
    step(2);
    Resetn   = 1'b1;
    runCount = 0;
  endtask

  task automatic clearRoms();
    for (int i = 0; i < 32; i++) rom1[i] = 9'd0;
    for (int i = 0; i < 4; i++) rom2[i] = 9'd0;
  endtask

  initial begin
    clearRoms();
    Resetn = 1'b0;
    Start  = 1'b0;
    Done   = 1'b0;

    $display("[TB] reset values and single mv");
    rom1[0] = 9'o010;
    rom1[1] = 9'o700;
    doReset();
    checkOutput("rst_din", din1, 0);
    checkOutput("rst_addr", memAddr1, 0);
    checkOutput("rst_run", run1, 0);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_halted", halted1, 0);
    checkOutput("rst_error", error1, 0);
    checkOutput("rst_count", issueCount1, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mv_fi_busy", busy1, 1);
    checkOutput("mv_fi_addr", memAddr1, 0);
    step(1);
    checkOutput("mv_li_addr", memAddr1, 1);
    checkOutput("mv_li_run", run1, 0);
    step(1);
    checkOutput("mv_run_cycle4", run1, 1);
    checkOutput("mv_din", din1, 9'o010);
    step(1);
    checkOutput("mv_exec_run", run1, 0);
    checkOutput("mv_count", issueCount1, 1);
    step(1);
    checkOutput("mv_exec_addr", memAddr1, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("mv_next_addr", memAddr1, 1);
    checkOutput("mv_next_busy", busy1, 1);
    step(2);
    checkOutput("mv_halted", halted1, 1);
    checkOutput("mv_halt_addr", memAddr1, 1);
    checkOutput("mv_halt_busy", busy1, 0);
    checkOutput("mv_runs", runCount, 1);

    $display("[TB] mvi with immediate, then HALT and restart");
    clearRoms();
    rom1[0] = 9'o120;
    rom1[1] = 9'h005;
    rom1[2] = 9'o700;
    doReset();
    applyStimulus(1'b1, 1'b0);
    step(3);
    checkOutput("mvi_run", run1, 1);
    checkOutput("mvi_din_ir", din1, 9'o120);
    step(1);
    checkOutput("mvi_t0_run", run1, 0);
    checkOutput("mvi_din_imm", din1, 9'h005);
    step(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("mvi_next_addr", memAddr1, 2);
    step(2);
    checkOutput("mvi_halted", halted1, 1);
    checkOutput("mvi_halt_pc", memAddr1, 2);
    checkOutput("mvi_count", issueCount1, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_halted", halted1, 0);
    checkOutput("restart_count", issueCount1, 0);
    checkOutput("restart_addr", memAddr1, 0);
    checkOutput("restart_busy", busy1, 1);

    $display("[TB] add with Done at n+4");
    clearRoms();
    rom1[0] = 9'o201;
    rom1[1] = 9'o700;
    doReset();
    applyStimulus(1'b1, 1'b0);
    step(2);
    checkOutput("add_run", run1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput("add_busy", busy1, 1);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("add_fi_addr", memAddr1, 1);
    checkOutput("add_fi_busy", busy1, 1);
    checkOutput("add_runs", runCount, 1);

    $display("[TB] Done on the last timeout cycle");
    clearRoms();
    rom1[0] = 9'o010;
    rom1[1] = 9'o700;
    doReset();
    applyStimulus(1'b1, 1'b0);
    step(2);
    step(8);
    applyStimulus(1'b0, 1'b1);
    checkOutput("edge_error", error1, 0);
    checkOutput("edge_addr", memAddr1, 1);
    checkOutput("edge_busy", busy1, 1);

    $display("[TB] Done timeout");
    doReset();
    applyStimulus(1'b1, 1'b0);
    step(2);
    step(8);
    checkOutput("to_pre_error", error1, 0);
    checkOutput("to_pre_busy", busy1, 1);
    step(1);
    checkOutput("to_error", error1, 1);
    checkOutput("to_busy", busy1, 0);
    checkOutput("to_run", run1, 0);
    runCount = 0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    step(2);
    checkOutput("to_no_run", runCount, 0);
    checkOutput("to_sticky", error1, 1);
    checkOutput("to_idle_busy", busy1, 0);

    $display("[TB] mvi at top address wraps (ADDR_W=2)");
    rom2[0] = 9'h0AA;
    rom2[1] = 9'o110;
    rom2[2] = 9'h003;
    rom2[3] = 9'o130;
    doReset();
    applyStimulus(1'b1, 1'b0);
    step(4);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrap_pc1", memAddr2, 1);
    step(5);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrap_pc3", memAddr2, 3);
    step(1);
    checkOutput("wrap_imm_addr", memAddr2, 0);
    step(2);
    checkOutput("wrap_run", run2, 1);
    checkOutput("wrap_din_ir", din2, 9'o130);
    step(1);
    checkOutput("wrap_din_imm", din2, 9'h0AA);
    step(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrap_next_pc", memAddr2, 1);

    $display("[TB] reset during EXEC, Start while busy");
    clearRoms();
    rom1[0] = 9'o201;
    doReset();
    applyStimulus(1'b1, 1'b0);
    step(3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("busy_start_addr", memAddr1, 0);
    checkOutput("busy_start_busy", busy1, 1);
    Resetn = 1'b0;
    step(1);
    checkOutput("mid_rst_din", din1, 0);
    checkOutput("mid_rst_addr", memAddr1, 0);
    checkOutput("mid_rst_run", run1, 0);
    checkOutput("mid_rst_busy", busy1, 0);
    checkOutput("mid_rst_halted", halted1, 0);
    checkOutput("mid_rst_error", error1, 0);
    checkOutput("mid_rst_count", issueCount1, 0);
    Resetn   = 1'b1;
    runCount = 0;
    step(3);
    checkOutput("post_rst_runs", runCount, 0);
    checkOutput("post_rst_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
